// File: rtl/vx_rr_req_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : vx_rr_req_scheduler
//  Purpose  : Round-robin N:1 request arbiter feeding a one-entry output buffer
//  Revision : 1.0
// ============================================================================
module vx_rr_req_scheduler #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LN         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            valid_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQS-1:0]            ready_in,
  output logic                           valid_out,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [LN-1:0]                  sel_out,
  input  logic                           ready_out
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [LN-1:0]         ptr_q, ptr_d;
  logic [LN-1:0]         sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [NUM_REQS-1:0]   hi_mask, hi_valid;
  logic [LN-1:0]         hi_idx, lo_idx, grant_idx;
  logic                  grant_vld, enable, xfer;
  logic [DATA_WIDTH-1:0] grant_data;

  // Requesters at or above ptr win first; otherwise wrap to the lowest valid one.
  always_comb begin : arbiter
    hi_mask = '0;
    hi_idx  = '0;
    lo_idx  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      hi_mask[i] = (LN'(i) >= ptr_q);
    end
    hi_valid = valid_in & hi_mask;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (hi_valid[i]) hi_idx = LN'(i);
      if (valid_in[i]) lo_idx = LN'(i);
    end
    grant_vld = |valid_in;
    grant_idx = (|hi_valid) ? hi_idx : lo_idx;
  end

  always_comb begin : data_mux
    grant_data = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_idx == LN'(i)) grant_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign valid_out = (state_q == ST_FULL);
  assign enable    = ~valid_out | ready_out;
  assign xfer      = grant_vld & enable & ~reset;

  always_comb begin : ready_gen
    ready_in = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      ready_in[i] = xfer & (grant_idx == LN'(i));
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (xfer) begin
      state_d = ST_FULL;
      sel_d   = grant_idx;
      data_d  = grant_data;
      ptr_d   = (grant_idx == LN'(NUM_REQS - 1)) ? '0 : grant_idx + LN'(1);
    end else if (ready_out) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign data_out = data_q;
  assign sel_out  = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_rr_req_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vx_rr_req_scheduler
//  Purpose  : Directed and random checks of the round-robin request scheduler
//  Revision : 1.0
// ============================================================================
module tb_vx_rr_req_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    valid_in;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    ready_in;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic [LW-1:0]   sel_out;
  logic            ready_out;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: the buffered item and the current round-robin pointer.
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_sel;
  int            m_ptr;

  vx_rr_req_scheduler #(.NUM_REQS(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .sel_out   (sel_out),
    .ready_out (ready_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  // One clock: drive, check ready_in, advance reference across the edge, check outputs.
  task automatic cycle(input logic [N-1:0] v, input logic ro);
    int         g;
    logic       en;
    logic [N-1:0] exp_rdy;
    valid_in  = v;
    ready_out = ro;
    #2;
    en      = !m_valid || ro;
    g       = model_grant(v, m_ptr);
    exp_rdy = (g >= 0 && en) ? (N'(1) << g) : '0;
    chk("ready_in", 32'(ready_in), 32'(exp_rdy));
    @(posedge clk);
    if (g >= 0 && en) begin
      m_valid = 1'b1;
      m_sel   = g;
      m_data  = data_in[g*DW +: DW];
      m_ptr   = (g + 1) % N;
    end else if (ro) begin
      m_valid = 1'b0;
    end
    #1;
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("data_out",  32'(data_out),  32'(m_data));
    chk("sel_out",   32'(sel_out),   32'(m_sel));
  endtask

  initial begin
    reset     = 1'b1;
    valid_in  = 4'b1111;
    ready_out = 1'b1;
    data_in   = 32'hA3A2A1A0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out",  32'(data_out),  32'd0);
    chk("rst_sel_out",   32'(sel_out),   32'd0);
    chk("rst_ready_in",  32'(ready_in),  32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle: nothing requested, nothing moves.
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1);

    // Rotation with all requesters active.
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b1);
      chk("rot_sel",  32'(sel_out),  32'(i % N));
      chk("rot_data", 32'(data_out), 32'(8'hA0 + (i % N)));
    end

    // Stall with sel_out=2, then resume: next grant is requester 3.
    cycle(4'b0100, 1'b1);
    chk("stall_pre_sel", 32'(sel_out), 32'd2);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1011, 1'b0);
      chk("stall_rdy", 32'(ready_in), 32'd0);
      chk("stall_sel", 32'(sel_out),  32'd2);
      chk("stall_dat", 32'(data_out), 32'hA2);
    end
    cycle(4'b1011, 1'b1);
    chk("stall_resume_sel", 32'(sel_out), 32'd3);

    // Sparse wrap: ptr=3 with requesters 0 and 2.
    cycle(4'b0100, 1'b1);
    cycle(4'b0101, 1'b1);
    chk("wrap_sel0", 32'(sel_out), 32'd0);
    cycle(4'b0101, 1'b1);
    chk("wrap_sel2", 32'(sel_out), 32'd2);

    // Drain without refill leaves the pointer alone.
    cycle(4'b0000, 1'b1);
    chk("drain_valid", 32'(valid_out), 32'd0);
    cycle(4'b1111, 1'b1);
    chk("drain_ptr_sel", 32'(sel_out), 32'd3);

    // Asynchronous reset while holding requester 1.
    cycle(4'b0010, 1'b1);
    chk("mid_pre_sel", 32'(sel_out), 32'd1);
    valid_in = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_valid_out", 32'(valid_out), 32'd0);
    chk("mid_sel_out",   32'(sel_out),   32'd0);
    chk("mid_ready_in",  32'(ready_in),  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(4'b1111, 1'b1);
    chk("post_rst_sel", 32'(sel_out), 32'd0);

    // Random traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      data_in = $urandom;
      cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vx_rr_req_scheduler.md
VX_RR_REQ_SCHEDULER -- requirements
Module: VX_rr_req_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of requesters, legal range 1..32.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width per requester.
REQ-003 SHALL have parameter LN, default LOG2UP(NUM_REQS): width of the index port.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; the ports are named clk and reset.
REQ-005 Port clk: input, 1 bit, the clock; all state changes on the rising edge.
REQ-006 Port reset: input, 1 bit, asynchronous active-high reset.
REQ-007 Port valid_in: input, NUM_REQS bits, per-requester request valid.
REQ-008 Port data_in: input, NUM_REQS*DATA_WIDTH bits, payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port ready_in: output, NUM_REQS bits, per-requester accept; a transfer occurs when valid_in[i] and ready_in[i] are both high.
REQ-010 Port valid_out: output, 1 bit, output buffer holds an item.
REQ-011 Port data_out: output, DATA_WIDTH bits, buffered payload.
REQ-012 Port sel_out: output, LN bits, index of the requester that produced data_out.
REQ-013 Port ready_out: input, 1 bit, downstream accept.

Function
REQ-014 SHALL contain a single-entry output buffer with two states: EMPTY (valid_out=0) and FULL (valid_out=1).
REQ-015 enable = ~valid_out | ready_out.
REQ-016 Arbitration SHALL be round-robin:
- A pointer ptr (LN bits) marks the highest-priority requester.
- The grant goes to the first i with valid_in[i]=1, searching ptr, ptr+1, ..., wrapping modulo NUM_REQS.
REQ-017 ready_in SHALL be one-hot or zero: ready_in[g]=enable for the granted g; all other bits are 0.
- ready_in is 0 when no valid_in bit is set.
REQ-018 ready_in SHALL be combinational from valid_in, ptr, valid_out and ready_out, with no dependence on data_in.
REQ-019 On a transfer, at the next edge:
- data_out <= data_in[g]
- sel_out <= g
- valid_out <= 1
- ptr <= (g+1) mod NUM_REQS, so g NUM_REQS-1 wraps ptr to 0.
REQ-020 If valid_out=1 and ready_out=1 with no transfer, valid_out SHALL go to 0 at the next edge.
- data_out and sel_out hold their values.
- ptr is unchanged.
REQ-021 If valid_out=1 and ready_out=1 and a transfer occurs in the same cycle, the buffer SHALL be refilled.
- valid_out stays 1.
- Throughput is one item per cycle.
REQ-022 If valid_out=1 and ready_out=0 (stall):
- ready_in SHALL be all zero.
- data_out, sel_out, valid_out and ptr SHALL hold.
REQ-023 Latency SHALL be exactly one cycle from transfer to valid_out.
REQ-024 ptr SHALL change only on a transfer; idle cycles do not advance it.
REQ-025 With NUM_REQS=1:
- sel_out SHALL be constant 0.
- ptr SHALL be constant 0.
- The block acts as a one-entry pipeline register.
REQ-026 A requester that stays valid SHALL be granted within NUM_REQS transfers (no starvation).

Reset
REQ-027 While reset=1, outputs SHALL be forced: valid_out=0, data_out=0, sel_out=0, ptr=0, ready_in=0.
REQ-028 Reset asserted mid-operation SHALL discard the buffered item with no output handshake.
REQ-029 The first cycle after reset deassertion SHALL arbitrate with ptr=0.

Verification
REQ-030 Reset then idle. Stimulus: NUM_REQS=4, DATA_WIDTH=8, valid_in=0000. Response: valid_out=0 and ready_in=0000 every cycle; ptr stays 0.
REQ-031 Rotation. Stimulus: valid_in=1111 held, ready_out=1, data_in[i]=8'hA0+i. Response: sel_out sequence 0,1,2,3,0; data_out A0,A1,A2,A3,A0; valid_out=1 every cycle from cycle 1.
REQ-032 Stall. Stimulus: buffer FULL with sel_out=2, ready_out=0 for 3 cycles while valid_in=1011. Response: ready_in=0000 and data_out/sel_out stable for 3 cycles; after ready_out=1, next grant is requester 3.
REQ-033 Wrap with sparse requests. Stimulus: ptr=3, valid_in=0101. Response: requester 0 is granted; ptr becomes 1; next grant is requester 2.
REQ-034 Reset mid-stream. Stimulus: assert reset while valid_out=1, sel_out=1. Response: valid_out=0, sel_out=0 immediately, with no clock edge required; first post-reset grant with valid_in=1111 is requester 0.
REQ-035 Drain without refill. Stimulus: valid_out=1, ready_out=1, valid_in=0000. Response: valid_out=0 next cycle; ptr unchanged.
